// File: rtl/avr_mem_router.sv
// avr_mem_router
//   Routes AVR CPU data-space accesses to NREG memory regions with per-region
//   wait states, an optional bank extension of the address, a bank register
//   mapped at BANK_ADDR and a fault pulse for unmapped accesses.
//
// Ports
//   clock        sole clock
//   reset_n      synchronous active-low reset
//   address      CPU data address
//   data_o       CPU write data
//   wren / rden  CPU write / read request (both high = write)
//   data_i       read data returned to the CPU
//   stall        holds the CPU while wait states are counted
//   mem_address  shared memory address {bank-or-zero, address}
//   mem_data     shared memory write data
//   mem_sel      one-hot region select
//   mem_wren     per-region write strobe
//   mem_q        per-region read data, one cycle after the select
//   bank         current bank register
//   fault        one-cycle pulse after an unmapped access
module avr_mem_router #(
  parameter int                     NREG       = 4,
  parameter int                     BANK_W     = 4,
  parameter int                     WAIT_W     = 3,
  parameter logic [15:0]            BANK_ADDR  = 16'h005B,
  parameter logic [NREG*16-1:0]     REG_BASE   = {16'h4000, 16'hC000, 16'h0000, 16'h0000},
  parameter logic [NREG*16-1:0]     REG_MASK   = {16'hE000, 16'hF000, 16'h4000, 16'hE000},
  parameter logic [NREG*WAIT_W-1:0] REG_WAIT   = {3'd2, 3'd3, 3'd1, 3'd0},
  parameter logic [NREG-1:0]        REG_BANKED = 4'b0010
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [15:0]            address,
  input  logic [7:0]             data_o,
  input  logic                   wren,
  input  logic                   rden,
  output logic [7:0]             data_i,
  output logic                   stall,
  output logic [16+BANK_W-1:0]   mem_address,
  output logic [7:0]             mem_data,
  output logic [NREG-1:0]        mem_sel,
  output logic [NREG-1:0]        mem_wren,
  input  logic [NREG*8-1:0]      mem_q,
  output logic [BANK_W-1:0]      bank,
  output logic                   fault
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, LAST} state_t;

  state_t              state;
  logic [WAIT_W-1:0]   cnt;

  // Transaction captured when a wait-stated access is accepted
  logic [15:0]         addr_l;
  logic [7:0]          data_l;
  logic [BANK_W-1:0]   ext_l;
  logic [IDX_W-1:0]    idx_l;
  logic                wr_l;

  // Read-return path: rd_pend selects the region's mem_q for one cycle,
  // data_q holds the last returned value otherwise
  logic                rd_pend;
  logic [IDX_W-1:0]    rd_idx;
  logic [7:0]          data_q;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [WAIT_W-1:0]   hit_wait;
  logic                hit_banked;
  logic [BANK_W-1:0]   ext_now;
  logic                req, new_req, acc_bank, acc_mem, acc_none, acc_fast;

  // Descending scan so the lowest hitting region is the last assignment
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((address & REG_MASK[i*16 +: 16]) == REG_BASE[i*16 +: 16]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit_wait   = REG_WAIT[int'(hit_idx)*WAIT_W +: WAIT_W];
  assign hit_banked = REG_BANKED[hit_idx];
  assign ext_now    = hit_banked ? bank : {BANK_W{1'b0}};

  assign req      = wren | rden;
  assign new_req  = (state == IDLE) && req;
  assign acc_bank = new_req && (address == BANK_ADDR);
  assign acc_mem  = new_req && (address != BANK_ADDR) && hit;
  assign acc_none = new_req && (address != BANK_ADDR) && !hit;
  assign acc_fast = acc_mem && (hit_wait == '0);

  // Cycle 0 is driven straight from the decode; later cycles replay the
  // latched transaction so the bus stays constant while the CPU is held.
  // Write strobes are gated by reset_n so a reset aborts a pending write.
  always_comb begin
    mem_sel     = '0;
    mem_wren    = '0;
    mem_address = {ext_now, address};
    mem_data    = data_o;
    stall       = 1'b0;
    if (state == IDLE) begin
      if (acc_mem) begin
        mem_sel[hit_idx] = 1'b1;
        if (acc_fast) begin
          mem_wren[hit_idx] = wren & reset_n;
        end else begin
          stall = 1'b1;
        end
      end
    end else begin
      mem_sel[idx_l] = 1'b1;
      mem_address    = {ext_l, addr_l};
      mem_data       = data_l;
      if (state == WAIT) begin
        stall = 1'b1;
      end else begin
        mem_wren[idx_l] = wr_l & reset_n;
      end
    end
  end

  assign data_i = rd_pend ? mem_q[int'(rd_idx)*8 +: 8] : data_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bank    <= '0;
      fault   <= 1'b0;
      rd_pend <= 1'b0;
      data_q  <= 8'hFF;
    end else begin
      fault   <= acc_none;
      rd_pend <= 1'b0;
      data_q  <= data_i;
      case (state)
        IDLE: begin
          if (acc_bank) begin
            if (wren) bank   <= data_o[BANK_W-1:0];
            else      data_q <= 8'(bank);
          end else if (acc_none) begin
            if (!wren) data_q <= 8'hFF;
          end else if (acc_fast) begin
            if (!wren) begin
              rd_pend <= 1'b1;
              rd_idx  <= hit_idx;
            end
          end else if (acc_mem) begin
            addr_l <= address;
            data_l <= data_o;
            ext_l  <= ext_now;
            idx_l  <= hit_idx;
            wr_l   <= wren;
            cnt    <= hit_wait;
            // A single wait state needs no counting: go straight to release
            state  <= (hit_wait == WAIT_W'(1)) ? LAST : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - WAIT_W'(1);
          if (cnt == WAIT_W'(2)) state <= LAST;
        end
        LAST: begin
          if (!wr_l) begin
            rd_pend <= 1'b1;
            rd_idx  <= idx_l;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_mem_router.sv
// Testbench for avr_mem_router: region map, bank register, wait states,
// unmapped faults and reset aborts, against a transaction-level model.
module tb_avr_mem_router;

  logic        clock, reset_n;
  logic [15:0] address;
  logic [7:0]  data_o;
  logic        wren, rden;
  logic [7:0]  data_i;
  logic        stall;
  logic [19:0] mem_address;
  logic [7:0]  mem_data;
  logic [3:0]  mem_sel, mem_wren;
  logic [31:0] mem_q;
  logic [3:0]  bank;
  logic        fault;

  avr_mem_router #(
    .NREG(4), .BANK_W(4), .WAIT_W(3), .BANK_ADDR(16'h005B),
    .REG_BASE({16'h4000, 16'hC000, 16'h0000, 16'h0000}),
    .REG_MASK({16'hE000, 16'hF000, 16'h4000, 16'hE000}),
    .REG_WAIT({3'd2, 3'd3, 3'd1, 3'd0}),
    .REG_BANKED(4'b0010)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_o(data_o),
    .wren(wren), .rden(rden), .data_i(data_i), .stall(stall),
    .mem_address(mem_address), .mem_data(mem_data), .mem_sel(mem_sel),
    .mem_wren(mem_wren), .mem_q(mem_q), .bank(bank), .fault(fault)
  );

  // Region map as the bench sees it
  localparam logic [15:0] T_BASE   [4] = '{16'h0000, 16'h0000, 16'hC000, 16'h4000};
  localparam logic [15:0] T_MASK   [4] = '{16'hE000, 16'h4000, 16'hF000, 16'hE000};
  localparam int          T_WAIT   [4] = '{0, 1, 3, 2};
  localparam bit          T_BANKED [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          w;
    bit          r;
    logic [3:0]  sel;
    int          stalls;
    int          wcyc;
    logic [19:0] maddr;
    bit          flt;
    logic [7:0]  rdata;
  } vec_t;

  typedef struct {
    logic [3:0]  sel0;
    int          stalls;
    int          wcyc;
    logic [3:0]  wren_or;
    logic [19:0] addr0;
    logic [7:0]  wdata;
    bit          held;
    bit          flt;
    bit          flt2;
    logic [7:0]  rdata;
    bit          idle_after;
  } obs_t;

  int tests = 0;
  int fails = 0;

  // Memory environment: synchronous read, one cycle latency
  logic [7:0]  ram [logic [21:0]];
  logic [21:0] rk;

  // Reference model state
  logic [7:0]  mdl [logic [21:0]];
  logic [3:0]  mbank;
  logic [7:0]  mlast;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    mem_q = '0;
    forever begin
      @(posedge clock);
      for (int i = 0; i < 4; i++) begin
        if (mem_sel[i]) begin
          rk = {2'(i), mem_address};
          mem_q[i*8 +: 8] <= ram.exists(rk) ? ram[rk] : 8'h00;
          if (mem_wren[i]) ram[rk] = mem_data;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level prediction: lowest hitting region, W stall cycles,
  // write strobe in cycle W, read data from model memory.
  task automatic predict(input logic [15:0] a, input logic [7:0] d,
                         input bit w, input bit r, output vec_t v);
    int ri;
    logic [21:0] key;
    ri = -1;
    for (int i = 3; i >= 0; i--)
      if ((a & T_MASK[i]) == T_BASE[i]) ri = i;
    v.a = a; v.d = d; v.w = w; v.r = r;
    v.sel = 4'h0; v.stalls = 0; v.wcyc = -1; v.maddr = 20'h0; v.flt = 1'b0;
    v.rdata = mlast;
    if (a == 16'h005B) begin
      if (w) mbank = d[3:0];
      else begin mlast = {4'h0, mbank}; v.rdata = mlast; end
    end else if (ri >= 0) begin
      v.sel    = 4'(1 << ri);
      v.stalls = T_WAIT[ri];
      v.maddr  = T_BANKED[ri] ? {mbank, a} : {4'h0, a};
      key      = {2'(ri), v.maddr};
      if (w) begin
        v.wcyc   = T_WAIT[ri];
        mdl[key] = d;
      end else begin
        mlast   = mdl.exists(key) ? mdl[key] : 8'h00;
        v.rdata = mlast;
      end
    end else begin
      v.flt = 1'b1;
      if (!w) begin mlast = 8'hFF; v.rdata = 8'hFF; end
    end
  endtask

  // CPU-like master: holds the request while stalled (with junk on the
  // address/data lines after cycle 0), drops it after the release cycle.
  task automatic run_txn(input vec_t v, output obs_t o);
    int cyc;
    bit done;
    o.sel0 = 0; o.stalls = 0; o.wcyc = -1; o.wren_or = 0; o.addr0 = 0;
    o.wdata = 0; o.held = 1; o.flt = 0; o.flt2 = 0; o.rdata = 0; o.idle_after = 0;
    address = v.a; data_o = v.d; wren = v.w; rden = v.r;
    cyc = 0; done = 0;
    while (!done && cyc < 12) begin
      @(negedge clock);
      if (cyc == 0) begin
        o.sel0 = mem_sel; o.addr0 = mem_address;
      end else if (mem_sel !== o.sel0 || mem_address !== o.addr0) begin
        o.held = 0;
      end
      if (mem_wren != 4'h0) begin
        if (o.wcyc < 0) o.wcyc = cyc;
        o.wren_or |= mem_wren;
        o.wdata = mem_data;
      end
      if (stall) o.stalls++;
      else done = 1;
      @(posedge clock); #1;
      cyc++;
      if (!done) begin address = 16'($urandom); data_o = 8'($urandom); end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout: stall still high after %0d cycles at address %h", cyc, v.a);
    end
    wren = 0; rden = 0; address = 16'h0; data_o = 8'h0;
    @(negedge clock);
    o.rdata = data_i; o.flt = fault; o.idle_after = !stall && (mem_sel == 4'h0);
    @(posedge clock); #1;
    @(negedge clock);
    o.flt2 = fault;
    @(posedge clock); #1;
  endtask

  task automatic compare(input vec_t v, input obs_t o, input string tag);
    chk({tag, ".sel"},    32'(o.sel0),   32'(v.sel));
    chk({tag, ".stalls"}, 32'(o.stalls), 32'(v.stalls));
    chk({tag, ".wcyc"},   32'(o.wcyc),   32'(v.wcyc));
    chk({tag, ".wren"},   32'(o.wren_or), 32'(v.w ? v.sel : 4'h0));
    if (v.sel != 4'h0) chk({tag, ".maddr"}, 32'(o.addr0), 32'(v.maddr));
    if (v.wcyc >= 0)   chk({tag, ".wdata"}, 32'(o.wdata), 32'(v.d));
    chk({tag, ".held"},   32'(o.held),   32'h1);
    chk({tag, ".fault"},  32'(o.flt),    32'(v.flt));
    chk({tag, ".fault2"}, 32'(o.flt2),   32'h0);
    chk({tag, ".rdata"},  32'(o.rdata),  32'(v.rdata));
    chk({tag, ".idle"},   32'(o.idle_after), 32'h1);
  endtask

  vec_t vecs [15];
  vec_t pv;
  obs_t ob;
  logic [3:0] wseen;

  initial begin
    // a, d, w, r, sel, stalls, wcyc, maddr, fault, rdata
    vecs = '{
      '{16'h0100, 8'hA5, 1'b1, 1'b0, 4'b0001, 0,  0, 20'h00100, 1'b0, 8'hFF},
      '{16'h0100, 8'h00, 1'b0, 1'b1, 4'b0001, 0, -1, 20'h00100, 1'b0, 8'hA5},
      '{16'hC010, 8'h3C, 1'b1, 1'b0, 4'b0100, 3,  3, 20'h0C010, 1'b0, 8'hA5},
      '{16'hC010, 8'h00, 1'b0, 1'b1, 4'b0100, 3, -1, 20'h0C010, 1'b0, 8'h3C},
      '{16'h005B, 8'h07, 1'b1, 1'b0, 4'b0000, 0, -1, 20'h00000, 1'b0, 8'h3C},
      '{16'h8000, 8'h5A, 1'b1, 1'b0, 4'b0010, 1,  1, 20'h78000, 1'b0, 8'h3C},
      '{16'h005B, 8'h00, 1'b0, 1'b1, 4'b0000, 0, -1, 20'h00000, 1'b0, 8'h07},
      '{16'h8000, 8'h00, 1'b0, 1'b1, 4'b0010, 1, -1, 20'h78000, 1'b0, 8'h5A},
      '{16'hF000, 8'h11, 1'b1, 1'b0, 4'b0000, 0, -1, 20'h00000, 1'b1, 8'h5A},
      '{16'hF000, 8'h00, 1'b0, 1'b1, 4'b0000, 0, -1, 20'h00000, 1'b1, 8'hFF},
      '{16'h0100, 8'h66, 1'b1, 1'b1, 4'b0001, 0,  0, 20'h00100, 1'b0, 8'hFF},
      '{16'h0100, 8'h00, 1'b0, 1'b1, 4'b0001, 0, -1, 20'h00100, 1'b0, 8'h66},
      '{16'h4000, 8'hC3, 1'b1, 1'b0, 4'b1000, 2,  2, 20'h04000, 1'b0, 8'h66},
      '{16'h5FFF, 8'h00, 1'b0, 1'b1, 4'b1000, 2, -1, 20'h05FFF, 1'b0, 8'h00},
      '{16'h4000, 8'h00, 1'b0, 1'b1, 4'b1000, 2, -1, 20'h04000, 1'b0, 8'hC3}
    };
    mbank = 4'h0; mlast = 8'hFF;
    reset_n = 0; address = 16'h0; data_o = 8'h0; wren = 0; rden = 0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst.stall",  32'(stall),    32'h0);
    chk("rst.sel",    32'(mem_sel),  32'h0);
    chk("rst.wren",   32'(mem_wren), 32'h0);
    chk("rst.fault",  32'(fault),    32'h0);
    chk("rst.bank",   32'(bank),     32'h0);
    chk("rst.data_i", 32'(data_i),   32'hFF);
    @(posedge clock); #1;
    reset_n = 1;

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      predict(vecs[i].a, vecs[i].d, vecs[i].w, vecs[i].r, pv);
      run_txn(vecs[i], ob);
      compare(vecs[i], ob, $sformatf("vec%0d", i));
    end

    // Reset in cycle 1 of a 3-wait-state write
    wseen = 4'h0;
    address = 16'hC020; data_o = 8'h99; wren = 1; rden = 0;
    @(negedge clock);
    chk("abort1.stall0", 32'(stall), 32'h1);
    wseen |= mem_wren;
    @(posedge clock); #1;
    reset_n = 0;
    @(negedge clock);
    wseen |= mem_wren;
    @(posedge clock); #1;
    reset_n = 1; wren = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      wseen |= mem_wren;
      if (k == 0) begin
        chk("abort1.stall",  32'(stall),   32'h0);
        chk("abort1.sel",    32'(mem_sel), 32'h0);
        chk("abort1.bank",   32'(bank),    32'h0);
        chk("abort1.data_i", 32'(data_i),  32'hFF);
      end
      @(posedge clock); #1;
    end
    chk("abort1.wren", 32'(wseen), 32'h0);
    mbank = 4'h0; mlast = 8'hFF;
    predict(16'hC020, 8'h00, 1'b0, 1'b1, pv);
    run_txn(pv, ob);
    compare(pv, ob, "abort1.rd");

    // Reset in the release cycle of a 3-wait-state write
    wseen = 4'h0;
    address = 16'hC030; data_o = 8'hAA; wren = 1; rden = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) reset_n = 0;
      @(negedge clock);
      wseen |= mem_wren;
      @(posedge clock); #1;
    end
    reset_n = 1; wren = 0;
    @(negedge clock);
    chk("abort2.wren",   32'(wseen),  32'h0);
    chk("abort2.data_i", 32'(data_i), 32'hFF);
    @(posedge clock); #1;
    mbank = 4'h0; mlast = 8'hFF;
    predict(16'hC030, 8'h00, 1'b0, 1'b1, pv);
    run_txn(pv, ob);
    compare(pv, ob, "abort2.rd");

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      logic [1:0]  mode;
      int kind;
      kind = $urandom_range(0, 5);
      mode = 2'($urandom_range(1, 3));
      case (kind)
        0:       a = 16'h0000 | 16'($urandom_range(0, 3));
        1:       a = 16'h8000 | 16'($urandom_range(0, 3));
        2:       a = 16'hC000 | 16'($urandom_range(0, 3));
        3:       a = 16'h4000 | 16'($urandom_range(0, 3));
        4:       a = 16'h005B;
        default: a = 16'hF000 | 16'($urandom_range(0, 255));
      endcase
      predict(a, 8'($urandom), mode[0], mode[1], pv);
      run_txn(pv, ob);
      compare(pv, ob, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
